// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the control unit and muldiv_unit.
//   start_i/kill_i/funct3_i/rs1_data_i/rs2_data_i/rd_addr_i : issue side
//   busy_o/done_o/result_o/rd_addr_o/wr_en_o                : completion / RF write side
// slave modport is the execution unit; master is the issuing control unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start_i;
  logic            kill_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            wr_en_o;

  modport slave (
    input  start_i, kill_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    output busy_o, done_o, result_o, rd_addr_o, wr_en_o
  );

  modport master (
    output start_i, kill_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    input  busy_o, done_o, result_o, rd_addr_o, wr_en_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply,
// restoring divide), one operation in flight, fixed 34-cycle latency.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - muldiv_if.slave: start/kill/funct3/operands/rd in;
//           busy/done/result/rd_addr/wr_en out (all registered)
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned     ACC_W     = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_ADJUST = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Operation context captured when a start is accepted.
  typedef struct packed {
    logic [2:0]      funct3;
    logic            neg_a;   // operand A was negative and treated as signed
    logic            neg_b;   // operand B was negative and treated as signed
    logic            ovf;     // signed INT_MIN / -1
    logic [XLEN-1:0] a_raw;   // original dividend, returned on REM by zero
    logic [XLEN-1:0] a_mag;   // multiplicand magnitude / dividend magnitude
    logic [XLEN-1:0] b_mag;   // multiplier magnitude / divisor magnitude
  } op_ctx_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  op_ctx_t          ctx_q, ctx_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;

  op_ctx_t          new_ctx;
  logic             a_signed, b_signed;
  logic [ACC_W-1:0] mul_next, div_next;
  logic [XLEN:0]    mul_sum, div_trial;
  logic [ACC_W-1:0] prod_adj;
  logic [XLEN-1:0]  quo_adj, rem_adj, adj_result;
  logic             res_neg, b_zero;

  // Decode operand signedness and build the context for a new operation.
  always_comb begin
    a_signed = (bus.funct3_i == F_MULH) || (bus.funct3_i == F_MULHSU) ||
               (bus.funct3_i == F_DIV)  || (bus.funct3_i == F_REM);
    b_signed = (bus.funct3_i == F_MULH) || (bus.funct3_i == F_DIV) ||
               (bus.funct3_i == F_REM);
    new_ctx        = '0;
    new_ctx.funct3 = bus.funct3_i;
    new_ctx.neg_a  = a_signed & bus.rs1_data_i[XLEN-1];
    new_ctx.neg_b  = b_signed & bus.rs2_data_i[XLEN-1];
    new_ctx.ovf    = ((bus.funct3_i == F_DIV) || (bus.funct3_i == F_REM)) &&
                     (bus.rs1_data_i == INT_MIN) && (bus.rs2_data_i == '1);
    new_ctx.a_raw  = bus.rs1_data_i;
    new_ctx.a_mag  = new_ctx.neg_a ? -bus.rs1_data_i : bus.rs1_data_i;
    new_ctx.b_mag  = new_ctx.neg_b ? -bus.rs2_data_i : bus.rs2_data_i;
  end

  // One shift-add step: acc = {product high, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, ctx_q.a_mag};
    mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                        : {1'b0, acc_q[ACC_W-1:1]};
  end

  // One restoring-divide step: acc = {partial remainder, dividend/quotient}.
  // Because remainder < divisor, bit XLEN of the trial is the borrow.
  always_comb begin
    div_trial = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]} - {1'b0, ctx_q.b_mag};
    div_next  = div_trial[XLEN] ? {acc_q[ACC_W-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction, special cases and result selection.
  always_comb begin
    res_neg  = ctx_q.neg_a ^ ctx_q.neg_b;
    b_zero   = (ctx_q.b_mag == '0);
    prod_adj = res_neg ? -acc_q : acc_q;
    quo_adj  = res_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_adj  = ctx_q.neg_a ? -acc_q[ACC_W-1:XLEN] : acc_q[ACC_W-1:XLEN];
    adj_result = '0;
    case (ctx_q.funct3)
      F_MUL:                     adj_result = prod_adj[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: adj_result = prod_adj[ACC_W-1:XLEN];
      F_DIV, F_DIVU: begin
        if (b_zero)         adj_result = '1;
        else if (ctx_q.ovf) adj_result = INT_MIN;
        else                adj_result = quo_adj;
      end
      F_REM, F_REMU: begin
        if (b_zero)         adj_result = ctx_q.a_raw;
        else if (ctx_q.ovf) adj_result = '0;
        else                adj_result = rem_adj;
      end
      default:              adj_result = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ctx_d     = ctx_q;
    result_d  = result_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // kill takes priority over a simultaneous start
        if (bus.start_i && !bus.kill_i) begin
          ctx_d     = new_ctx;
          rd_addr_d = bus.rd_addr_i;
          cnt_d     = '0;
          acc_d     = new_ctx.funct3[2] ? {XLEN'(0), new_ctx.a_mag}
                                        : {XLEN'(0), new_ctx.b_mag};
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.kill_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = ctx_q.funct3[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_d = S_ADJUST;
        end
      end
      S_ADJUST: begin
        if (bus.kill_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = adj_result;
          done_d   = 1'b1;
          wr_en_d  = (rd_addr_q != 5'd0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ctx_q     <= '0;
      result_q  <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ctx_q     <= ctx_d;
      result_q  <= result_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.result_o  = result_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.wr_en_o   = wr_en_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the RS1/RS2 read data for an M-extension instruction and computes the result over a fixed number of cycles.
- Returns the result with a write-enable pulse and destination address, which drive the register file write port (data_i, wr_en_i, RD_ADDR_i).
- One operation in flight at a time; start/busy/done handshake toward the control unit.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold values 0..XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- kill_i  input  1  abort the in-flight operation (pipeline flush).
- funct3_i  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  32  operand A (from RS1_data_o).
- rs2_data_i  input  32  operand B (from RS2_data_o).
- rd_addr_i  input  5  destination register.
- busy_o  output  1  high from the cycle after start is accepted until done_o drops.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  32  operation result; holds its value until the next accepted start.
- rd_addr_o  output  5  latched destination register.
- wr_en_o  output  1  equals done_o AND (rd_addr_o != 0).

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE. busy_o, done_o, wr_en_o, result_o, rd_addr_o and all internal registers go to 0. Reset asserted mid-operation discards the operation with no done_o pulse.
- FSM states: IDLE, CALC, ADJUST, DONE.
- IDLE:
  - On start_i=1 at edge E0: latch funct3, rd_addr and both operands.
  - Convert signed operands to magnitudes, recording the result sign per op: MULH both signed; MULHSU only A signed; DIV/REM signed; MUL uses low bits, so sign treatment is irrelevant.
  - Clear counter, go to CALC.
- CALC, exactly 32 edges (E1..E32):
  - Multiply: shift-add, one multiplier bit per cycle into a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle; 32-bit remainder with a 33-bit trial subtract.
  - Counter reaching 31 at the edge moves to ADJUST.
- ADJUST, 1 edge (E33): apply sign correction (two's complement of the 64-bit product, or of quotient/remainder), then apply the special cases below. Select output:
  - MUL: low 32 bits of product.
  - MULH, MULHSU, MULHU: high 32 bits of product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Write result_o. Go to DONE.
- DONE: done_o=1 for exactly one cycle (the cycle after E33; latency 34 cycles from the start-sampling edge), wr_en_o per the port rule. Next edge returns to IDLE.
- busy_o=1 in CALC, ADJUST and DONE. A new start is accepted only in IDLE; back-to-back issue is possible on the edge ending DONE+1.
- Special cases (full latency still applies):
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start_i while busy: ignored; latched operands unchanged.
- kill_i=1 in CALC or ADJUST: return to IDLE on that edge; no done_o; result_o unchanged.
- kill_i in DONE: ignored, the pulse completes.
- kill_i and start_i together in IDLE: kill wins, start dropped.
- Operand inputs may change freely after the start edge.

Test Plan:
- Latency and MUL: MUL A=7, B=0xFFFFFFFD -> done_o exactly 34 cycles after start, result_o=0xFFFFFFEB, rd_addr_o=rd, wr_en_o=1 with rd=5.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- Signed division: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All take 34 cycles.
- Handshake and abort:
  - start_i pulsed at cycle 10 of a busy op -> ignored, first result correct.
  - kill_i at cycle 20 -> no done_o, busy_o low next cycle.
  - rst_n low at cycle 15 -> all outputs 0 immediately, no done_o.
- x0 destination: MUL 3*4 with rd=0 -> done_o=1, result_o=12, wr_en_o stays 0.
